// File: rtl/bfm_hamming_match_core.sv
// bfm_hamming_match_core
// Multi-query Hamming-distance matcher. Loads C_NUM_QUERY query descriptors,
// streams train descriptors through a 3-stage XOR / popcount / compare
// pipeline, tracks best / second-best distance and best index per lane, then
// reports one result per lane in lane order.
// Optional feature macro: BFM_RATIO_TEST_EN. When defined, res_match carries
// the ratio test (4*best < 3*second). When undefined, res_match is always 1.

module bfm_hamming_match_core #(
   parameter int C_DESC_WIDTH = 256,
   parameter int C_BUS_WIDTH  = 128,
   parameter int C_NUM_QUERY  = 4,
   parameter int C_IDX_WIDTH  = 16,
   localparam int D = $clog2(C_DESC_WIDTH + 1),
   localparam int L = (C_NUM_QUERY > 1) ? $clog2(C_NUM_QUERY) : 1
) (
   input  logic                    sap_clk,
   input  logic                    sap_rst,
   input  logic                    cfg_start,
   output logic                    busy,
   input  logic                    qry_valid,
   output logic                    qry_ready,
   input  logic [C_BUS_WIDTH-1:0]  qry_data,
   input  logic                    trn_valid,
   output logic                    trn_ready,
   input  logic [C_BUS_WIDTH-1:0]  trn_data,
   input  logic                    trn_last,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [L-1:0]            res_lane,
   output logic [C_IDX_WIDTH-1:0]  res_best_idx,
   output logic [D-1:0]            res_best_dist,
   output logic [D-1:0]            res_second_dist,
   output logic                    res_match
);

   localparam int B  = C_DESC_WIDTH / C_BUS_WIDTH;
   localparam int BW = (B > 1) ? $clog2(B) : 1;

   localparam logic [BW-1:0] LAST_BEAT = BW'(B - 1);
   localparam logic [L-1:0]  LAST_LANE = L'(C_NUM_QUERY - 1);
   localparam logic [D-1:0]  DIST_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_Q,
      S_STREAM,
      S_DRAIN,
      S_REPORT
   } state_t;

   state_t                   state;

   logic [BW-1:0]            qry_beat;
   logic [L-1:0]             qry_lane;
   logic [C_DESC_WIDTH-1:0]  qry_mem [C_NUM_QUERY];

   logic [BW-1:0]            trn_beat;
   logic [C_DESC_WIDTH-1:0]  trn_buf;
   logic [C_DESC_WIDTH-1:0]  trn_next;
   logic [C_IDX_WIDTH-1:0]   trn_idx;

   logic                     s0_valid;
   logic [C_IDX_WIDTH-1:0]   s0_idx;
   logic                     s1_valid;
   logic [C_IDX_WIDTH-1:0]   s1_idx;
   logic [C_DESC_WIDTH-1:0]  s1_xor [C_NUM_QUERY];
   logic                     s2_valid;
   logic [C_IDX_WIDTH-1:0]   s2_idx;
   logic [D-1:0]             s2_dist [C_NUM_QUERY];

   logic [D-1:0]             best_dist   [C_NUM_QUERY];
   logic [D-1:0]             second_dist [C_NUM_QUERY];
   logic [C_IDX_WIDTH-1:0]   best_idx    [C_NUM_QUERY];

   logic                     job_start;
   logic                     qry_fire;
   logic                     trn_fire;
   logic                     res_fire;
   logic                     qry_done;
   logic                     desc_done;
   logic                     pipe_empty;
   logic [L-1:0]             next_lane;
   logic [L-1:0]             sel_lane;
   logic [D-1:0]             sel_best;
   logic [D-1:0]             sel_second;
   logic [C_IDX_WIDTH-1:0]   sel_idx;
   logic                     sel_match;

   // Number of set bits in a full-width XOR vector.
   function automatic logic [D-1:0] popcount(input logic [C_DESC_WIDTH-1:0] vec);
      logic [D-1:0] n;
      n = '0;
      for (int i = 0; i < C_DESC_WIDTH; i++) begin
         n = n + D'(vec[i]);
      end
      return n;
   endfunction

   assign job_start  = (state == S_IDLE) && cfg_start;
   assign qry_fire   = qry_valid && qry_ready;
   assign trn_fire   = trn_valid && trn_ready;
   assign res_fire   = res_valid && res_ready;
   assign qry_done   = qry_fire && (qry_beat == LAST_BEAT) && (qry_lane == LAST_LANE);
   assign desc_done  = trn_fire && (trn_beat == LAST_BEAT);
   assign pipe_empty = !s0_valid && !s1_valid && !s2_valid;

   // Result source lane: lane 0 when leaving DRAIN, otherwise the lane after the one on display.
   assign next_lane  = res_lane + 1'b1;
   assign sel_lane   = (state == S_REPORT) ? next_lane : '0;
   assign sel_best   = best_dist[sel_lane];
   assign sel_second = second_dist[sel_lane];
   assign sel_idx    = best_idx[sel_lane];

`ifdef BFM_RATIO_TEST_EN
   // Ratio test 4*best < 3*second in D+3 bits so neither side can overflow.
   function automatic logic ratio_pass(input logic [D-1:0] best, input logic [D-1:0] second);
      logic [D+2:0] lhs;
      logic [D+2:0] rhs;
      lhs = {1'b0, best, 2'b00};
      rhs = {3'b000, second} + {2'b00, second, 1'b0};
      return lhs < rhs;
   endfunction

   assign sel_match = ratio_pass(sel_best, sel_second);
`else
   assign sel_match = 1'b1;
`endif

   // New train beats enter from the top so beat 0 ends up in the low bits.
   generate
      if (B == 1) begin : g_single_beat
         assign trn_next = trn_data;
      end else begin : g_multi_beat
         assign trn_next = {trn_data, trn_buf[C_DESC_WIDTH-1:C_BUS_WIDTH]};
      end
   endgenerate

   // Job control FSM with registered handshake and result outputs.
   always_ff @(posedge sap_clk or negedge sap_rst) begin
      if (!sap_rst) begin
         state           <= S_IDLE;
         busy            <= 1'b0;
         qry_ready       <= 1'b0;
         trn_ready       <= 1'b0;
         res_valid       <= 1'b0;
         res_lane        <= '0;
         res_best_idx    <= '0;
         res_best_dist   <= '0;
         res_second_dist <= '0;
         res_match       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  state     <= S_LOAD_Q;
                  busy      <= 1'b1;
                  qry_ready <= 1'b1;
               end
            end
            S_LOAD_Q: begin
               if (qry_done) begin
                  state     <= S_STREAM;
                  qry_ready <= 1'b0;
                  trn_ready <= 1'b1;
               end
            end
            S_STREAM: begin
               if (desc_done && trn_last) begin
                  state     <= S_DRAIN;
                  trn_ready <= 1'b0;
               end
            end
            S_DRAIN: begin
               if (pipe_empty) begin
                  state           <= S_REPORT;
                  res_valid       <= 1'b1;
                  res_lane        <= '0;
                  res_best_idx    <= sel_idx;
                  res_best_dist   <= sel_best;
                  res_second_dist <= sel_second;
                  res_match       <= sel_match;
               end
            end
            S_REPORT: begin
               if (res_fire) begin
                  if (res_lane == LAST_LANE) begin
                     state     <= S_IDLE;
                     res_valid <= 1'b0;
                     busy      <= 1'b0;
                  end else begin
                     res_lane        <= next_lane;
                     res_best_idx    <= sel_idx;
                     res_best_dist   <= sel_best;
                     res_second_dist <= sel_second;
                     res_match       <= sel_match;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Query loader: lane-major, beat-minor placement into the per-lane query store.
   always_ff @(posedge sap_clk or negedge sap_rst) begin
      if (!sap_rst) begin
         qry_beat <= '0;
         qry_lane <= '0;
         for (int i = 0; i < C_NUM_QUERY; i++) begin
            qry_mem[i] <= '0;
         end
      end else if (job_start) begin
         qry_beat <= '0;
         qry_lane <= '0;
      end else if (qry_fire) begin
         qry_mem[qry_lane][qry_beat*C_BUS_WIDTH +: C_BUS_WIDTH] <= qry_data;
         if (qry_beat == LAST_BEAT) begin
            qry_beat <= '0;
            qry_lane <= qry_lane + 1'b1;
         end else begin
            qry_beat <= qry_beat + 1'b1;
         end
      end
   end

   // Train assembler: collects beats and tags each complete descriptor with its index.
   always_ff @(posedge sap_clk or negedge sap_rst) begin
      if (!sap_rst) begin
         trn_beat <= '0;
         trn_buf  <= '0;
         trn_idx  <= '0;
         s0_valid <= 1'b0;
         s0_idx   <= '0;
      end else if (job_start) begin
         trn_beat <= '0;
         trn_idx  <= '0;
         s0_valid <= 1'b0;
      end else begin
         s0_valid <= desc_done;
         if (trn_fire) begin
            trn_buf <= trn_next;
            if (trn_beat == LAST_BEAT) begin
               trn_beat <= '0;
               s0_idx   <= trn_idx;
               trn_idx  <= trn_idx + 1'b1;
            end else begin
               trn_beat <= trn_beat + 1'b1;
            end
         end
      end
   end

   // Stage 1: XOR the assembled train descriptor against every query lane.
   always_ff @(posedge sap_clk or negedge sap_rst) begin
      if (!sap_rst) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         for (int i = 0; i < C_NUM_QUERY; i++) begin
            s1_xor[i] <= '0;
         end
      end else begin
         s1_valid <= s0_valid;
         if (s0_valid) begin
            s1_idx <= s0_idx;
            for (int i = 0; i < C_NUM_QUERY; i++) begin
               s1_xor[i] <= qry_mem[i] ^ trn_buf;
            end
         end
      end
   end

   // Stage 2: reduce each XOR vector to a distance.
   always_ff @(posedge sap_clk or negedge sap_rst) begin
      if (!sap_rst) begin
         s2_valid <= 1'b0;
         s2_idx   <= '0;
         for (int i = 0; i < C_NUM_QUERY; i++) begin
            s2_dist[i] <= '0;
         end
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_idx <= s1_idx;
            for (int i = 0; i < C_NUM_QUERY; i++) begin
               s2_dist[i] <= popcount(s1_xor[i]);
            end
         end
      end
   end

   // Stage 3: per-lane best / second-best tracking; ties keep the earlier index.
   always_ff @(posedge sap_clk or negedge sap_rst) begin
      if (!sap_rst) begin
         for (int i = 0; i < C_NUM_QUERY; i++) begin
            best_dist[i]   <= DIST_MAX;
            second_dist[i] <= DIST_MAX;
            best_idx[i]    <= '0;
         end
      end else if (job_start) begin
         for (int i = 0; i < C_NUM_QUERY; i++) begin
            best_dist[i]   <= DIST_MAX;
            second_dist[i] <= DIST_MAX;
            best_idx[i]    <= '0;
         end
      end else if (s2_valid) begin
         for (int i = 0; i < C_NUM_QUERY; i++) begin
            if (s2_dist[i] < best_dist[i]) begin
               second_dist[i] <= best_dist[i];
               best_dist[i]   <= s2_dist[i];
               best_idx[i]    <= s2_idx;
            end else if (s2_dist[i] < second_dist[i]) begin
               second_dist[i] <= s2_dist[i];
            end
         end
      end
   end

endmodule

// File: tb/tb_bfm_hamming_match_core.sv
// tb_bfm_hamming_match_core
// Self-checking bench for bfm_hamming_match_core with 256-bit descriptors,
// 128-bit beats and two query lanes. Honours BFM_RATIO_TEST_EN for res_match.

module tb_bfm_hamming_match_core;

   localparam int NQ = 2;

   logic          sap_clk = 1'b0;
   logic          sap_rst;
   logic          cfg_start;
   logic          busy;
   logic          qry_valid;
   logic          qry_ready;
   logic [127:0]  qry_data;
   logic          trn_valid;
   logic          trn_ready;
   logic [127:0]  trn_data;
   logic          trn_last;
   logic          res_valid;
   logic          res_ready;
   logic [0:0]    res_lane;
   logic [15:0]   res_best_idx;
   logic [8:0]    res_best_dist;
   logic [8:0]    res_second_dist;
   logic          res_match;

   int vecCount  = 0;
   int missCount = 0;

   logic [255:0] qv [NQ];
   logic [255:0] trq [$];
   int           expIdx    [NQ];
   int           expBest   [NQ];
   int           expSecond [NQ];
   bit           expMatch  [NQ];

   typedef struct {
      logic [255:0] q0;
      logic [255:0] q1;
      int           nTrain;
      logic [255:0] t0;
      logic [255:0] t1;
      logic [255:0] t2;
      int           idx0;
      int           best0;
      int           second0;
      int           idx1;
      int           best1;
      int           second1;
   } vec_t;

   vec_t vecTable [3];

   bfm_hamming_match_core #(
      .C_DESC_WIDTH (256),
      .C_BUS_WIDTH  (128),
      .C_NUM_QUERY  (NQ),
      .C_IDX_WIDTH  (16)
   ) dut (
      .sap_clk         (sap_clk),
      .sap_rst         (sap_rst),
      .cfg_start       (cfg_start),
      .busy            (busy),
      .qry_valid       (qry_valid),
      .qry_ready       (qry_ready),
      .qry_data        (qry_data),
      .trn_valid       (trn_valid),
      .trn_ready       (trn_ready),
      .trn_data        (trn_data),
      .trn_last        (trn_last),
      .res_valid       (res_valid),
      .res_ready       (res_ready),
      .res_lane        (res_lane),
      .res_best_idx    (res_best_idx),
      .res_best_dist   (res_best_dist),
      .res_second_dist (res_second_dist),
      .res_match       (res_match)
   );

   // 100 MHz free-running clock.
   always #5 sap_clk = ~sap_clk;

   // Hard stop in case a handshake never completes.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   task automatic timeoutFail(input string name);
      vecCount++;
      missCount++;
      $display("[TB] FAIL %s: actual=timeout required=handshake", name);
   endtask

   function automatic logic [255:0] randDesc();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic bit refMatch(input int best, input int second);
`ifdef BFM_RATIO_TEST_EN
      return (4 * best) < (3 * second);
`else
      return 1'b1;
`endif
   endfunction

   // Reference: scan every train descriptor in order, applying the best/second rule.
   task automatic buildExpected();
      for (int l = 0; l < NQ; l++) begin
         int best   = 511;
         int second = 511;
         int idx    = 0;
         for (int i = 0; i < trq.size(); i++) begin
            int d = $countones(qv[l] ^ trq[i]);
            if (d < best) begin
               second = best;
               best   = d;
               idx    = i & 16'hFFFF;
            end else if (d < second) begin
               second = d;
            end
         end
         expIdx[l]    = idx;
         expBest[l]   = best;
         expSecond[l] = second;
         expMatch[l]  = refMatch(best, second);
      end
   endtask

   task automatic pushBeat(input bit isTrain, input logic [127:0] data, input logic last, input bit gaps);
      int waitCnt = 0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge sap_clk); #1;
         end
      end
      if (isTrain) begin
         trn_valid = 1'b1;
         trn_data  = data;
         trn_last  = last;
      end else begin
         qry_valid = 1'b1;
         qry_data  = data;
      end
      while (((isTrain && !trn_ready) || (!isTrain && !qry_ready)) && waitCnt < 50) begin
         @(posedge sap_clk); #1;
         waitCnt++;
      end
      if (waitCnt >= 50) timeoutFail(isTrain ? "trn_ready_wait" : "qry_ready_wait");
      @(posedge sap_clk); #1;
      trn_valid = 1'b0;
      trn_last  = 1'b0;
      qry_valid = 1'b0;
   endtask

   task automatic startJob();
      cfg_start = 1'b1;
      @(posedge sap_clk); #1;
      cfg_start = 1'b0;
      checkOutput("busy_after_start", busy, 1);
   endtask

   task automatic loadQueries(input bit gaps);
      for (int l = 0; l < NQ; l++) begin
         logic [255:0] q = qv[l];
         for (int b = 0; b < 2; b++) pushBeat(1'b0, q[b*128 +: 128], 1'b0, gaps);
      end
   endtask

   task automatic sendTrain(input int i, input bit gaps);
      logic [255:0] t = trq[i];
      for (int b = 0; b < 2; b++) begin
         pushBeat(1'b1, t[b*128 +: 128], (i == trq.size() - 1) && (b == 1), gaps);
      end
   endtask

   task automatic collectResults(input bit stallRes);
      for (int l = 0; l < NQ; l++) begin
         int waitCnt = 0;
         while (!res_valid && waitCnt < 50) begin
            @(posedge sap_clk); #1;
            waitCnt++;
         end
         if (waitCnt >= 50) timeoutFail("res_valid_wait");
         checkOutput($sformatf("lane%0d_lane", l), res_lane, l);
         checkOutput($sformatf("lane%0d_idx", l), res_best_idx, expIdx[l]);
         checkOutput($sformatf("lane%0d_best", l), res_best_dist, expBest[l]);
         checkOutput($sformatf("lane%0d_second", l), res_second_dist, expSecond[l]);
         checkOutput($sformatf("lane%0d_match", l), res_match, expMatch[l]);
         if (stallRes && l == 0) begin
            repeat (5) begin
               @(posedge sap_clk); #1;
               checkOutput("stall_valid", res_valid, 1);
               checkOutput("stall_lane", res_lane, 0);
               checkOutput("stall_idx", res_best_idx, expIdx[0]);
               checkOutput("stall_best", res_best_dist, expBest[0]);
               checkOutput("stall_second", res_second_dist, expSecond[0]);
            end
         end
         res_ready = 1'b1;
         @(posedge sap_clk); #1;
         res_ready = 1'b0;
      end
      checkOutput("busy_done", busy, 0);
      checkOutput("res_valid_done", res_valid, 0);
   endtask

   // Full job: start, load queries, stream trains, check latency, collect results.
   task automatic applyStimulus(input bit gaps, input bit stallRes, input bit pokeStart);
      int edges = 0;
      startJob();
      loadQueries(gaps);
      for (int i = 0; i < trq.size(); i++) begin
         sendTrain(i, gaps);
         if (pokeStart && i == 0 && trq.size() > 1) begin
            cfg_start = 1'b1;
            @(posedge sap_clk); #1;
            cfg_start = 1'b0;
            checkOutput("poke_busy", busy, 1);
            checkOutput("poke_qry_ready", qry_ready, 0);
            checkOutput("poke_trn_ready", trn_ready, 1);
         end
      end
      checkOutput("trn_ready_drain", trn_ready, 0);
      while (!res_valid && edges < 20) begin
         @(posedge sap_clk); #1;
         edges++;
      end
      checkOutput("result_latency", edges, 4);
      collectResults(stallRes);
   endtask

   task automatic loadVector(input int v);
      qv[0] = vecTable[v].q0;
      qv[1] = vecTable[v].q1;
      trq.delete();
      trq.push_back(vecTable[v].t0);
      if (vecTable[v].nTrain > 1) trq.push_back(vecTable[v].t1);
      if (vecTable[v].nTrain > 2) trq.push_back(vecTable[v].t2);
      expIdx[0]    = vecTable[v].idx0;
      expBest[0]   = vecTable[v].best0;
      expSecond[0] = vecTable[v].second0;
      expIdx[1]    = vecTable[v].idx1;
      expBest[1]   = vecTable[v].best1;
      expSecond[1] = vecTable[v].second1;
      expMatch[0]  = refMatch(expBest[0], expSecond[0]);
      expMatch[1]  = refMatch(expBest[1], expSecond[1]);
   endtask

   task automatic randomJob();
      qv[0] = randDesc();
      qv[1] = ($urandom_range(0, 1) == 1) ? ~qv[0] : randDesc();
      trq.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) begin
         int kind = $urandom_range(0, 3);
         if (kind == 0 && trq.size() > 0) begin
            trq.push_back(trq[trq.size() - 1]);
         end else if (kind == 1) begin
            logic [255:0] mask = '0;
            for (int k = 0; k < $urandom_range(0, 12); k++) mask[$urandom_range(0, 255)] = 1'b1;
            trq.push_back(qv[$urandom_range(0, 1)] ^ mask);
         end else begin
            trq.push_back(randDesc());
         end
      end
      buildExpected();
   endtask

   initial begin
      sap_rst   = 1'b0;
      cfg_start = 1'b0;
      qry_valid = 1'b0;
      qry_data  = '0;
      trn_valid = 1'b0;
      trn_data  = '0;
      trn_last  = 1'b0;
      res_ready = 1'b0;

      vecTable[0] = '{q0: '0, q1: '1, nTrain: 3,
                      t0: 256'h0F, t1: {{248{1'b1}}, 8'h00}, t2: '0,
                      idx0: 2, best0: 0, second0: 4,
                      idx1: 1, best1: 8, second1: 252};
      vecTable[1] = '{q0: '0, q1: '1, nTrain: 2,
                      t0: 256'h3FF, t1: 256'h3FF, t2: '0,
                      idx0: 0, best0: 10, second0: 10,
                      idx1: 0, best1: 246, second1: 246};
      vecTable[2] = '{q0: '0, q1: '1, nTrain: 1,
                      t0: 256'hFF, t1: '0, t2: '0,
                      idx0: 0, best0: 8, second0: 511,
                      idx1: 0, best1: 248, second1: 511};

      $display("[TB] reset and idle");
      repeat (3) @(posedge sap_clk);
      #1;
      sap_rst = 1'b1;
      repeat (5) @(posedge sap_clk);
      #1;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_qry_ready", qry_ready, 0);
      checkOutput("rst_trn_ready", trn_ready, 0);
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_res_lane", res_lane, 0);
      checkOutput("rst_res_best_idx", res_best_idx, 0);
      checkOutput("rst_res_best_dist", res_best_dist, 0);
      checkOutput("rst_res_second_dist", res_second_dist, 0);
      checkOutput("rst_res_match", res_match, 0);

      $display("[TB] directed table");
      for (int v = 0; v < 3; v++) begin
         loadVector(v);
         applyStimulus(1'b0, 1'b0, 1'b0);
      end

      $display("[TB] backpressure on basic match");
      loadVector(0);
      applyStimulus(1'b1, 1'b1, 1'b0);

      $display("[TB] cfg_start while busy");
      loadVector(0);
      applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] mid-job reset and restart");
      qv[0] = randDesc();
      qv[1] = randDesc();
      trq.delete();
      for (int i = 0; i < 3; i++) trq.push_back(randDesc());
      startJob();
      loadQueries(1'b0);
      sendTrain(0, 1'b0);
      sap_rst = 1'b0;
      #1;
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_trn_ready", trn_ready, 0);
      checkOutput("midrst_qry_ready", qry_ready, 0);
      checkOutput("midrst_res_valid", res_valid, 0);
      repeat (2) @(posedge sap_clk);
      #1;
      sap_rst = 1'b1;
      repeat (6) begin
         @(posedge sap_clk); #1;
         checkOutput("no_stale_result", res_valid, 0);
      end
      randomJob();
      applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] randomized jobs");
      for (int j = 0; j < 6; j++) begin
         randomJob();
         applyStimulus(j[0], j == 2, j == 4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
